// File: rtl/alarm_clock.sv
// Wake-up source for the parent sequencer: counts a night period, rings until
// acknowledged, allows a bounded number of snoozes and counts acknowledged days.
//
// state  | meaning
// IDLE   | disarmed, waiting for enable
// COUNT  | night period running, cnt counts down to zero
// RING   | wakeup asserted, waiting for food_ack or snooze
// SNOOZE | wake-up postponed, cnt counts down to zero then re-ring
module alarm_clock #(
   parameter int PERIOD     = 16,
   parameter int SNOOZE_LEN = 4,
   parameter int MAX_SNOOZE = 2,
   parameter int DAY_W      = 4,
   localparam int SC_W      = (MAX_SNOOZE < 1) ? 1 : $clog2(MAX_SNOOZE + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             snooze,
   input  logic             food_ack,
   output logic             wakeup,
   output logic             ringing,
   output logic [SC_W-1:0]  snooze_cnt,
   output logic [DAY_W-1:0] day_cnt
);

   localparam int CNT_MAX = (PERIOD > SNOOZE_LEN) ? PERIOD : SNOOZE_LEN;
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_LEN - 1);
   localparam logic [SC_W-1:0]  SC_MAX    = SC_W'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      COUNT  = 2'b01,
      RING   = 2'b10,
      SNOOZE = 2'b11
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [SC_W-1:0]  snooze_cnt_nxt;
   logic [DAY_W-1:0] day_cnt_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         snooze_cnt <= '0;
         day_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         snooze_cnt <= snooze_cnt_nxt;
         day_cnt    <= day_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      snooze_cnt_nxt = snooze_cnt;
      day_cnt_nxt    = day_cnt;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (enable) begin
               state_nxt = COUNT;
               cnt_nxt   = PERIOD_LD;
            end
         end
         COUNT, SNOOZE: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - CNT_W'(1);
            end else begin
               state_nxt = RING;
            end
         end
         RING: begin
            // Acknowledge beats a simultaneous snooze request.
            if (food_ack) begin
               state_nxt      = COUNT;
               cnt_nxt        = PERIOD_LD;
               snooze_cnt_nxt = '0;
               day_cnt_nxt    = day_cnt + DAY_W'(1);
            end else if (snooze && (snooze_cnt < SC_MAX)) begin
               state_nxt      = SNOOZE;
               cnt_nxt        = SNOOZE_LD;
               snooze_cnt_nxt = snooze_cnt + SC_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Disarming wins over everything but keeps the day count.
      if (!enable) begin
         state_nxt      = IDLE;
         cnt_nxt        = '0;
         snooze_cnt_nxt = '0;
         day_cnt_nxt    = day_cnt;
      end
   end

   assign wakeup  = (state == RING);
   assign ringing = (state == RING) || (state == SNOOZE);

endmodule
